// File: rtl/ram2p_fifo_ctrl_pkg.sv
// Shared constants for the 256x116 descriptor FIFO and its pointer-width helper.
package ram2p_fifo_ctrl_pkg;

  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result++;
      remain = remain >> 1;
    end
    return result;
  endfunction

  localparam int FIFO_DEPTH  = 256;
  localparam int FIFO_ADDR_W = clog2(FIFO_DEPTH);
  localparam int FIFO_DATA_W = 116;

endpackage

// File: rtl/fifo_prefetch_buf.sv
// Two-entry register FIFO holding RAM read results; slot0 is the registered head.
module fifo_prefetch_buf
  import ram2p_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W
) (
  input  logic              clockCore,
  input  logic              resetCoreN,
  input  logic              capture,
  input  logic [DATA_W-1:0] captureData,
  input  logic              popFire,
  output logic [1:0]        outCount,
  output logic              popValid,
  output logic [DATA_W-1:0] popData
);

  logic [DATA_W-1:0] slot0;
  logic [DATA_W-1:0] slot1;

  always_ff @(posedge clockCore or negedge resetCoreN) begin
    if (!resetCoreN) begin
      slot0    <= '0;
      slot1    <= '0;
      outCount <= 2'd0;
    end else begin
      case ({capture, popFire})
        2'b10: begin
          if (outCount == 2'd0) slot0 <= captureData;
          else                  slot1 <= captureData;
          outCount <= outCount + 2'd1;
        end
        2'b01: begin
          slot0    <= slot1;
          outCount <= outCount - 2'd1;
        end
        2'b11: begin
          // Head leaves while a new entry lands: count holds, order shifts by one.
          if (outCount == 2'd1) begin
            slot0 <= captureData;
          end else begin
            slot0 <= slot1;
            slot1 <= captureData;
          end
        end
        default: ;
      endcase
    end
  end

  assign popValid = (outCount != 2'd0);
  assign popData  = slot0;

endmodule

// File: rtl/ram2p_fifo_ctrl.sv
// First-word-fall-through FIFO sequencer around an external 2-port RAM with
// 1-cycle read latency; pointers and read issue live here, head data in the prefetch buffer.
module ram2p_fifo_ctrl
  import ram2p_fifo_ctrl_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = clog2(DEPTH),
  parameter int DATA_W = FIFO_DATA_W
) (
  input  logic              clockCore,
  input  logic              resetCoreN,
  input  logic              pushValid,
  output logic              pushReady,
  input  logic [DATA_W-1:0] pushData,
  output logic              popValid,
  input  logic              popReady,
  output logic [DATA_W-1:0] popData,
  output logic [ADDR_W:0]   level,
  output logic              ramEnableWrite,
  output logic [ADDR_W-1:0] ramAddressWrite,
  output logic [DATA_W-1:0] ramWriteData,
  output logic              ramEnableRead,
  output logic [ADDR_W-1:0] ramAddressRead,
  input  logic [DATA_W-1:0] ramReadData
);

  logic [ADDR_W:0] wrPtr;
  logic [ADDR_W:0] rdPtr;
  logic [ADDR_W:0] ramCount;
  logic            ramEmpty;
  logic            ramFull;
  logic            resetDone;
  logic            readPending;
  logic            pushFire;
  logic            popFire;
  logic            readIssue;
  logic [1:0]      outCount;
  logic [2:0]      bufDemand;

  assign ramCount = wrPtr - rdPtr;
  assign ramEmpty = (wrPtr == rdPtr);
  // Equivalent to "wrap bits differ, low bits equal" since ramCount never exceeds DEPTH.
  assign ramFull  = (ramCount == (ADDR_W+1)'(DEPTH));

  // resetDone keeps pushReady low while reset is held and for the release edge.
  assign pushReady = resetDone & ~ramFull;
  assign pushFire  = pushValid & pushReady;
  assign popFire   = popValid & popReady;

  // Entries the buffer will hold after this edge if nothing new is issued.
  assign bufDemand = 3'(outCount) + 3'(readPending) - 3'(popFire);
  assign readIssue = ~ramEmpty && (bufDemand < 3'd2);

  always_ff @(posedge clockCore or negedge resetCoreN) begin
    if (!resetCoreN) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      readPending <= 1'b0;
      resetDone   <= 1'b0;
    end else begin
      resetDone   <= 1'b1;
      readPending <= readIssue;
      if (pushFire)  wrPtr <= wrPtr + (ADDR_W+1)'(1);
      if (readIssue) rdPtr <= rdPtr + (ADDR_W+1)'(1);
    end
  end

  assign ramEnableWrite  = pushFire;
  assign ramAddressWrite = wrPtr[ADDR_W-1:0];
  assign ramWriteData    = pushData;
  assign ramEnableRead   = readIssue;
  assign ramAddressRead  = rdPtr[ADDR_W-1:0];

  fifo_prefetch_buf #(
    .DATA_W (DATA_W)
  ) uPrefetch (
    .clockCore   (clockCore),
    .resetCoreN  (resetCoreN),
    .capture     (readPending),
    .captureData (ramReadData),
    .popFire     (popFire),
    .outCount    (outCount),
    .popValid    (popValid),
    .popData     (popData)
  );

  assign level = ramCount + (ADDR_W+1)'(readPending) + (ADDR_W+1)'(outCount);

endmodule

// File: tb/tb_ram2p_fifo_ctrl.sv
// Scoreboard bench for ram2p_fifo_ctrl with a behavioural 1-cycle-latency RAM beside it.
module tb_ram2p_fifo_ctrl;

  localparam int DW = 116;
  localparam int AW = 8;

  logic          clockCore = 1'b0;
  logic          resetCoreN;
  logic          pushValid;
  logic          pushReady;
  logic [DW-1:0] pushData;
  logic          popValid;
  logic          popReady;
  logic [DW-1:0] popData;
  logic [AW:0]   level;
  logic          ramEnableWrite;
  logic [AW-1:0] ramAddressWrite;
  logic [DW-1:0] ramWriteData;
  logic          ramEnableRead;
  logic [AW-1:0] ramAddressRead;
  logic [DW-1:0] ramReadData = '0;

  logic [DW-1:0] ramMem [0:255];

  int            checks = 0;
  int            failures = 0;
  int            modelLevel = 0;
  logic [AW-1:0] expWrAddr = '0;
  logic [DW-1:0] expQ [$];
  bit            monEn = 1'b0;

  ram2p_fifo_ctrl dut (
    .clockCore       (clockCore),
    .resetCoreN      (resetCoreN),
    .pushValid       (pushValid),
    .pushReady       (pushReady),
    .pushData        (pushData),
    .popValid        (popValid),
    .popReady        (popReady),
    .popData         (popData),
    .level           (level),
    .ramEnableWrite  (ramEnableWrite),
    .ramAddressWrite (ramAddressWrite),
    .ramWriteData    (ramWriteData),
    .ramEnableRead   (ramEnableRead),
    .ramAddressRead  (ramAddressRead),
    .ramReadData     (ramReadData)
  );

  always #5 clockCore = ~clockCore;

  always @(posedge clockCore) begin
    if (ramEnableWrite) ramMem[ramAddressWrite] <= ramWriteData;
    if (ramEnableRead)  ramReadData <= ramMem[ramAddressRead];
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: level against push/pop bookkeeping, write side, and head data on every pop.
  always @(negedge clockCore) begin
    if (monEn && resetCoreN) begin
      check("level", 128'(level), 128'(modelLevel));
      check("ramEnableWrite", 128'(ramEnableWrite), 128'(pushValid && pushReady));
      if (ramEnableWrite) begin
        check("ramAddressWrite", 128'(ramAddressWrite), 128'(expWrAddr));
        check("ramWriteData", 128'(ramWriteData), 128'(pushData));
        expWrAddr = expWrAddr + 8'd1;
      end
      if (popValid && popReady) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL popEmptyScoreboard: got pop of 0x%0h expected no pop", popData);
        end else begin
          check("popData", 128'(popData), 128'(expQ.pop_front()));
        end
      end
      modelLevel = modelLevel + ((pushValid && pushReady) ? 1 : 0)
                              - ((popValid && popReady) ? 1 : 0);
    end
  end

  task automatic checkResetOutputs(input string tag);
    check({tag, ".pushReady"}, 128'(pushReady), 128'(0));
    check({tag, ".popValid"}, 128'(popValid), 128'(0));
    check({tag, ".popData"}, 128'(popData), 128'(0));
    check({tag, ".level"}, 128'(level), 128'(0));
    check({tag, ".ramEnableRead"}, 128'(ramEnableRead), 128'(0));
    check({tag, ".ramEnableWrite"}, 128'(ramEnableWrite), 128'(0));
  endtask

  task automatic assertReset();
    resetCoreN = 1'b0;
    expQ.delete();
    modelLevel = 0;
    expWrAddr  = '0;
  endtask

  task automatic drainAll(input string tag, input int budget);
    @(posedge clockCore); #1;
    pushValid = 1'b0;
    popReady  = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clockCore);
      if (level == 0 && !popValid) break;
    end
    check({tag, ".level"}, 128'(level), 128'(0));
    check({tag, ".popValid"}, 128'(popValid), 128'(0));
    check({tag, ".scoreboardEmpty"}, 128'(expQ.size()), 128'(0));
    @(posedge clockCore); #1;
    popReady = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    int pops;
    int bubbles;
    bit stalled;
    bit primed;
    logic [DW-1:0] d;

    resetCoreN = 1'b0;
    pushValid  = 1'b0;
    pushData   = '0;
    popReady   = 1'b0;

    // Reset state
    repeat (3) @(posedge clockCore);
    #1;
    checkResetOutputs("reset");
    resetCoreN = 1'b1;
    monEn = 1'b1;
    @(posedge clockCore); #1;
    check("pushReadyAfterReset", 128'(pushReady), 128'(1));

    // Single push into empty FIFO: popValid appears after the second edge following the write
    pushValid = 1'b1;
    pushData  = 116'h1;
    if (pushReady) expQ.push_back(pushData);
    @(posedge clockCore); #1;
    pushValid = 1'b0;
    @(negedge clockCore);
    check("lat.popValidN", 128'(popValid), 128'(0));
    check("lat.ramEnableRead", 128'(ramEnableRead), 128'(1));
    check("lat.ramAddressRead", 128'(ramAddressRead), 128'(0));
    @(negedge clockCore);
    check("lat.popValidN1", 128'(popValid), 128'(0));
    @(negedge clockCore);
    check("lat.popValidN2", 128'(popValid), 128'(1));
    check("lat.popData", 128'(popData), 128'(1));
    @(posedge clockCore); #1;
    popReady = 1'b1;
    @(posedge clockCore); #1;
    popReady = 1'b0;
    @(negedge clockCore);
    check("lat.popValidAfterPop", 128'(popValid), 128'(0));

    // Fill with popReady low: 256 in RAM plus 2 prefetched
    accepted = 0;
    stalled  = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clockCore); #1;
      if (!pushReady) begin
        stalled = 1'b1;
        break;
      end
      pushValid = 1'b1;
      pushData  = DW'(32'h100 + accepted);
      expQ.push_back(pushData);
      accepted++;
    end
    pushValid = 1'b0;
    check("fill.stalled", 128'(stalled), 128'(1));
    check("fill.accepted", 128'(accepted), 128'(258));
    repeat (3) @(negedge clockCore);
    check("fill.level", 128'(level), 128'(258));
    check("fill.pushReady", 128'(pushReady), 128'(0));
    check("fill.popValid", 128'(popValid), 128'(1));
    check("fill.headHeld", 128'(popData), 128'(32'h100));

    // Full and popping in the same cycle: no push bypass
    @(posedge clockCore); #1;
    pushValid = 1'b1;
    pushData  = 116'hDEAD;
    popReady  = 1'b1;
    @(negedge clockCore);
    check("full.noBypass", 128'(pushReady), 128'(0));
    @(posedge clockCore); #1;
    pushValid = 1'b0;
    popReady  = 1'b0;

    // Drain: remaining 257 entries, one per cycle with no gaps
    @(posedge clockCore); #1;
    popReady = 1'b1;
    pops = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clockCore);
      if (popValid) pops++;
      else break;
    end
    check("drain.pops", 128'(pops), 128'(257));
    check("drain.level", 128'(level), 128'(0));
    check("drain.pushReady", 128'(pushReady), 128'(1));
    @(posedge clockCore); #1;
    popReady = 1'b0;

    // Streaming push+pop every cycle; pointers wrap several times
    primed  = 1'b0;
    bubbles = 0;
    popReady = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clockCore); #1;
      pushValid = 1'b1;
      pushData  = DW'(32'h20_0000 + c);
      if (pushReady) expQ.push_back(pushData);
      @(negedge clockCore);
      if (popValid) primed = 1'b1;
      else if (primed) bubbles++;
    end
    check("stream.primed", 128'(primed), 128'(1));
    check("stream.bubbles", 128'(bubbles), 128'(0));
    drainAll("stream", 50);

    // Random throttle on both sides
    for (int c = 0; c < 2000; c++) begin
      @(posedge clockCore); #1;
      d = DW'({$urandom(), $urandom(), $urandom(), $urandom()});
      pushValid = ($urandom_range(0, 3) != 0);
      pushData  = d;
      popReady  = ($urandom_range(0, 2) != 0);
      if (pushValid && pushReady) expQ.push_back(pushData);
    end
    drainAll("random", 400);

    // Reset while a read is in flight
    @(posedge clockCore); #1;
    pushValid = 1'b1;
    pushData  = 116'hA;
    if (pushReady) expQ.push_back(pushData);
    @(posedge clockCore); #1;
    pushValid = 1'b0;
    @(posedge clockCore); #1;
    assertReset();
    #1;
    checkResetOutputs("midReset");
    repeat (2) @(posedge clockCore);
    #1;
    resetCoreN = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clockCore);
      check("midReset.noStale", 128'(popValid), 128'(0));
    end
    @(posedge clockCore); #1;
    pushValid = 1'b1;
    pushData  = 116'hB;
    if (pushReady) expQ.push_back(pushData);
    @(posedge clockCore); #1;
    pushValid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clockCore);
      if (popValid) break;
    end
    check("midReset.newHead", 128'(popData), 128'(116'hB));
    drainAll("midReset", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
